mpu_load_stream: RTL and testbench

Parametrised multi-lane successor to the single-element matrix loader. The block accepts a load descriptor (address, M×N size, traversal order), streams LANES float_sp elements per beat from external memory under a valid/ready handshake, and presents them to the matrix register file. Each element is tagged with its (i,j) location and a lane-valid mask. A registered output stage supplies full backpressure.

---
 rtl/mpu_load_stream_pkg.sv | 37 +++
 rtl/mpu_load_stream_if.sv | 47 ++++
 rtl/mpu_load_stream_lane_gen.sv | 62 ++++++
 rtl/mpu_load_stream.sv | 138 +++++++++++++
 tb/tb_mpu_load_stream.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/mpu_load_stream_pkg.sv
// Shared sizing, state and descriptor types for the multi-lane matrix load streamer.
// This package provides the global_defs and mpu_data_types content used by mpu_load_stream.
package mpu_load_stream_pkg;

  localparam int LOAD_LANES_MAX  = 4;
  localparam int M               = 4;
  localparam int N               = 4;
  localparam int MBITS           = 2;
  localparam int NBITS           = 2;
  localparam int MATRIX_REG_BITS = 2;

  typedef enum logic [1:0] {
    LS_IDLE,
    LS_GRANT,
    LS_STREAM,
    LS_DONE
  } load_stream_state_e;

  typedef struct packed {
    logic [MATRIX_REG_BITS:0] addr;
    logic [MBITS:0]           m;
    logic [NBITS:0]           n;
    logic                     col_major;
  } load_desc_t;

  typedef struct packed {
    logic [MBITS:0] i;
    logic [NBITS:0] j;
  } lane_loc_t;

  // Zero-sized or oversized matrices are rejected at intake.
  function automatic logic desc_legal(input logic [MBITS:0] m, input logic [NBITS:0] n,
                                      input int m_max, input int n_max);
    return (m != '0) && (n != '0) && (int'(m) <= m_max) && (int'(n) <= n_max);
  endfunction

endpackage

// File: rtl/mpu_load_stream_if.sv
// Descriptor, memory-beat and register-file handshake bundle for mpu_load_stream.
// slave is the streamer's view; master is the view of whatever drives it.
interface mpu_load_stream_if #(
  parameter int LANES = 2
);
  import mpu_load_stream_pkg::*;

  logic                           load_req_in;
  logic [MATRIX_REG_BITS:0]       mem_load_addr_in;
  logic [MBITS:0]                 mem_m_load_size_in;
  logic [NBITS:0]                 mem_n_load_size_in;
  logic                           mem_col_major_in;
  logic                           mem_load_error_out;
  logic                           mem_load_ack_out;
  logic                           mem_valid_in;
  logic [LANES-1:0][31:0]         mem_element_in;
  logic                           mem_ready_out;
  logic                           reg_load_ready_in;
  logic                           reg_load_req_out;
  logic [MATRIX_REG_BITS:0]       reg_load_addr_out;
  logic [LANES-1:0][31:0]         reg_load_element_out;
  logic [LANES-1:0]               reg_lane_valid_out;
  logic [LANES-1:0][MBITS:0]      reg_i_load_loc_out;
  logic [LANES-1:0][NBITS:0]      reg_j_load_loc_out;
  logic [MBITS:0]                 reg_m_load_size_out;
  logic [NBITS:0]                 reg_n_load_size_out;
  logic                           load_done_out;

  modport slave (
    input  load_req_in, mem_load_addr_in, mem_m_load_size_in, mem_n_load_size_in,
           mem_col_major_in, mem_valid_in, mem_element_in, reg_load_ready_in,
    output mem_load_error_out, mem_load_ack_out, mem_ready_out, reg_load_req_out,
           reg_load_addr_out, reg_load_element_out, reg_lane_valid_out,
           reg_i_load_loc_out, reg_j_load_loc_out, reg_m_load_size_out,
           reg_n_load_size_out, load_done_out
  );

  modport master (
    output load_req_in, mem_load_addr_in, mem_m_load_size_in, mem_n_load_size_in,
           mem_col_major_in, mem_valid_in, mem_element_in, reg_load_ready_in,
    input  mem_load_error_out, mem_load_ack_out, mem_ready_out, reg_load_req_out,
           reg_load_addr_out, reg_load_element_out, reg_lane_valid_out,
           reg_i_load_loc_out, reg_j_load_loc_out, reg_m_load_size_out,
           reg_n_load_size_out, load_done_out
  );

endinterface

// File: rtl/mpu_load_stream_lane_gen.sv
// Combinational lane tagger: walks up to LANES elements from a base (i,j), wrapping as often as needed.
// Column-major stepping exists only when MPU_LOAD_TRANSPOSE_EN is defined.
module mpu_load_lane_gen
  import mpu_load_stream_pkg::*;
#(
  parameter int LANES = 2,
  parameter int CW    = MBITS + NBITS + 2
) (
  input  lane_loc_t                 base,
  input  logic [MBITS:0]            m,
  input  logic [NBITS:0]            n,
  input  logic                      col_major,
  input  logic [CW-1:0]             remaining,
  output logic [LANES-1:0][MBITS:0] loc_i,
  output logic [LANES-1:0][NBITS:0] loc_j,
  output logic [LANES-1:0]          mask,
  output lane_loc_t                 next_base
);

  localparam int MW = MBITS + 1;
  localparam int NW = NBITS + 1;

  lane_loc_t cur;

  // Lanes past the last element stay masked with a zero location.
  always_comb begin
    cur   = base;
    loc_i = '0;
    loc_j = '0;
    mask  = '0;
    for (int k = 0; k < LANES; k++) begin
      if (remaining > CW'(k)) begin
        mask[k]  = 1'b1;
        loc_i[k] = cur.i;
        loc_j[k] = cur.j;
`ifdef MPU_LOAD_TRANSPOSE_EN
        if (col_major) begin
          if (cur.i == m - MW'(1)) begin
            cur.i = '0;
            cur.j = cur.j + NW'(1);
          end else begin
            cur.i = cur.i + MW'(1);
          end
        end else
`endif
        if (cur.j == n - NW'(1)) begin
          cur.j = '0;
          cur.i = cur.i + MW'(1);
        end else begin
          cur.j = cur.j + NW'(1);
        end
      end
    end
    next_base = cur;
  end

`ifndef MPU_LOAD_TRANSPOSE_EN
  logic unused_col_inputs;
  assign unused_col_inputs = col_major ^ (^m);
`endif

endmodule

// File: rtl/mpu_load_stream.sv
// Multi-lane matrix load streamer: descriptor intake, per-lane (i,j) tagging and a registered output stage.
// Define MPU_LOAD_TRANSPOSE_EN to honour mem_col_major_in; otherwise every load is row-major.
module mpu_load_stream
  import mpu_load_stream_pkg::*;
#(
  parameter int LANES = 2,
  parameter int M_MAX = M,
  parameter int N_MAX = N
) (
  input logic              clk,
  input logic              rst_n,
  mpu_load_stream_if.slave bus
);

  localparam int CW = MBITS + NBITS + 2;

  load_stream_state_e        state_q, state_d;
  load_desc_t                desc_q;
  lane_loc_t                 base_q, next_base;
  logic [CW-1:0]             remaining_q;
  logic                      out_valid_q, ack_q, err_q;
  logic [LANES-1:0][31:0]    elem_q;
  logic [LANES-1:0]          mask_q, lane_mask;
  logic [LANES-1:0][MBITS:0] loc_i_q, lane_i;
  logic [LANES-1:0][NBITS:0] loc_j_q, lane_j;
  logic                      desc_ok, desc_bad, mem_ready, accept, consume, done;
  logic                      req_col;

`ifdef MPU_LOAD_TRANSPOSE_EN
  assign req_col = bus.mem_col_major_in;
`else
  logic unused_col_major;
  assign req_col          = 1'b0;
  assign unused_col_major = bus.mem_col_major_in;
`endif

  mpu_load_lane_gen #(.LANES(LANES), .CW(CW)) lane_gen (
    .base      (base_q),
    .m         (desc_q.m),
    .n         (desc_q.n),
    .col_major (desc_q.col_major),
    .remaining (remaining_q),
    .loc_i     (lane_i),
    .loc_j     (lane_j),
    .mask      (lane_mask),
    .next_base (next_base)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= LS_IDLE;
    else        state_q <= state_d;
  end

  // The input side may refill the output register in the same cycle it is drained.
  always_comb begin
    state_d   = state_q;
    desc_ok   = 1'b0;
    desc_bad  = 1'b0;
    mem_ready = 1'b0;
    done      = 1'b0;
    consume   = out_valid_q && bus.reg_load_ready_in;
    case (state_q)
      LS_IDLE: begin
        if (bus.load_req_in) begin
          if (desc_legal(bus.mem_m_load_size_in, bus.mem_n_load_size_in, M_MAX, N_MAX)) begin
            desc_ok = 1'b1;
            state_d = LS_GRANT;
          end else begin
            desc_bad = 1'b1;
          end
        end
      end
      LS_GRANT: if (bus.reg_load_ready_in) state_d = LS_STREAM;
      LS_STREAM: begin
        mem_ready = (remaining_q != '0) && (!out_valid_q || bus.reg_load_ready_in);
        if (consume && remaining_q == '0) state_d = LS_DONE;
      end
      LS_DONE: begin
        done    = 1'b1;
        state_d = LS_IDLE;
      end
      default: state_d = LS_IDLE;
    endcase
  end

  assign accept = mem_ready && bus.mem_valid_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      desc_q      <= '0;
      base_q      <= '0;
      remaining_q <= '0;
      out_valid_q <= 1'b0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      elem_q      <= '0;
      mask_q      <= '0;
      loc_i_q     <= '0;
      loc_j_q     <= '0;
    end else begin
      ack_q <= desc_ok;
      err_q <= desc_bad;
      if (desc_ok) begin
        desc_q.addr      <= bus.mem_load_addr_in;
        desc_q.m         <= bus.mem_m_load_size_in;
        desc_q.n         <= bus.mem_n_load_size_in;
        desc_q.col_major <= req_col;
        base_q           <= '0;
        remaining_q      <= CW'(bus.mem_m_load_size_in) * CW'(bus.mem_n_load_size_in);
      end
      if (accept) begin
        out_valid_q <= 1'b1;
        elem_q      <= bus.mem_element_in;
        mask_q      <= lane_mask;
        loc_i_q     <= lane_i;
        loc_j_q     <= lane_j;
        base_q      <= next_base;
        remaining_q <= (remaining_q > CW'(LANES)) ? remaining_q - CW'(LANES) : '0;
      end else if (consume) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.mem_load_ack_out     = ack_q;
  assign bus.mem_load_error_out   = err_q;
  assign bus.mem_ready_out        = mem_ready;
  assign bus.reg_load_req_out     = out_valid_q;
  assign bus.reg_load_addr_out    = desc_q.addr;
  assign bus.reg_load_element_out = elem_q;
  assign bus.reg_lane_valid_out   = mask_q;
  assign bus.reg_i_load_loc_out   = loc_i_q;
  assign bus.reg_j_load_loc_out   = loc_j_q;
  assign bus.reg_m_load_size_out  = desc_q.m;
  assign bus.reg_n_load_size_out  = desc_q.n;
  assign bus.load_done_out        = done;

endmodule

// File: tb/tb_mpu_load_stream.sv
// Self-checking bench for mpu_load_stream: directed loads plus randomized loads against an index-arithmetic model.
// Honours MPU_LOAD_TRANSPOSE_EN so the model matches the build.
module tb_mpu_load_stream;
  import mpu_load_stream_pkg::*;

  localparam int LANES = 2;
  localparam int EW    = LANES * 32;
  localparam int AW    = MATRIX_REG_BITS + 1;
  localparam int MW    = MBITS + 1;
  localparam int NW    = NBITS + 1;
`ifdef MPU_LOAD_TRANSPOSE_EN
  localparam bit TRANSPOSE = 1'b1;
`else
  localparam bit TRANSPOSE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   vectors     = 0;
  int   miscompares = 0;
  int   last_addr   = 0;
  int   last_m      = 0;
  int   last_n      = 0;

  always #5 clk = ~clk;

  mpu_load_stream_if #(.LANES(LANES)) bus ();

  mpu_load_stream #(.LANES(LANES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected beat b: element e = b*LANES+k sits at (e/n, e%n) row-major or (e%m, e/m) column-major.
  task automatic check_beat(input int b, input logic [EW-1:0] data, input int m, input int n, input bit col);
    logic [LANES-1:0]    emask;
    logic [LANES*MW-1:0] ei;
    logic [LANES*NW-1:0] ej;
    emask = '0;
    ei    = '0;
    ej    = '0;
    for (int k = 0; k < LANES; k++) begin
      int e;
      e = b * LANES + k;
      if (e < m * n) begin
        emask[k]        = 1'b1;
        ei[k*MW +: MW]  = MW'(col ? e % m : e / n);
        ej[k*NW +: NW]  = NW'(col ? e / m : e % n);
      end
    end
    check_output("beat_data", 64'(bus.reg_load_element_out), 64'(data));
    check_output("beat_mask", 64'(bus.reg_lane_valid_out), 64'(emask));
    check_output("beat_i",    64'(bus.reg_i_load_loc_out), 64'(ei));
    check_output("beat_j",    64'(bus.reg_j_load_loc_out), 64'(ej));
  endtask

  task automatic apply_stimulus(input int addr, input int m, input int n, input bit col, input bit ok);
    @(negedge clk);
    bus.mem_valid_in       = 1'b0;
    bus.reg_load_ready_in  = 1'b0;
    bus.load_req_in        = 1'b1;
    bus.mem_load_addr_in   = AW'(addr);
    bus.mem_m_load_size_in = MW'(m);
    bus.mem_n_load_size_in = NW'(n);
    bus.mem_col_major_in   = col;
    @(negedge clk);
    bus.load_req_in = 1'b0;
    #1;
    check_output("ack", 64'(bus.mem_load_ack_out), 64'(ok));
    check_output("err", 64'(bus.mem_load_error_out), 64'(!ok));
    if (ok) begin
      last_addr = addr;
      last_m    = m;
      last_n    = n;
    end else begin
      check_output("reject_mem_ready", 64'(bus.mem_ready_out), 64'(0));
    end
    check_output("addr_out",   64'(bus.reg_load_addr_out), 64'(last_addr));
    check_output("m_size_out", 64'(bus.reg_m_load_size_out), 64'(last_m));
    check_output("n_size_out", 64'(bus.reg_n_load_size_out), 64'(last_n));
  endtask

  task automatic stream_load(input int m, input int n, input bit col, input bit rnd, input bit stall);
    logic [EW-1:0] src [64];
    int beats, sent, got, stall_left, cyc;
    bit eff_col;
    eff_col    = col && TRANSPOSE;
    beats      = (m * n + LANES - 1) / LANES;
    sent       = 0;
    got        = 0;
    cyc        = 0;
    stall_left = stall ? 3 : 0;
    for (int b = 0; b < beats; b++)
      for (int k = 0; k < LANES; k++) src[b][k*32 +: 32] = $urandom;
    while (got < beats && cyc < 400) begin
      @(negedge clk);
      cyc++;
      bus.mem_valid_in      = (sent < beats) && (!rnd || $urandom_range(0, 3) != 0);
      bus.mem_element_in    = (sent < beats) ? src[sent] : '0;
      bus.reg_load_ready_in = !rnd || $urandom_range(0, 3) != 0;
      if (stall && got == 2 && stall_left > 0) begin
        bus.reg_load_ready_in = 1'b0;
        stall_left--;
      end
      #1;
      if (stall && got == 2 && !bus.reg_load_ready_in) begin
        check_output("stall_mem_ready", 64'(bus.mem_ready_out), 64'(0));
        check_output("stall_req",       64'(bus.reg_load_req_out), 64'(1));
        check_output("stall_hold_data", 64'(bus.reg_load_element_out), 64'(src[got]));
      end
      if (bus.reg_load_req_out && bus.reg_load_ready_in) begin
        check_beat(got, src[got], m, n, eff_col);
        got++;
      end
      if (bus.mem_valid_in && bus.mem_ready_out) sent++;
    end
    check_output("beats_consumed", 64'(got), 64'(beats));
    check_output("beats_sent",     64'(sent), 64'(beats));
    @(negedge clk);
    bus.mem_valid_in = 1'b0;
    #1;
    check_output("done_pulse", 64'(bus.load_done_out), 64'(1));
    @(negedge clk);
    #1;
    check_output("done_clear", 64'(bus.load_done_out), 64'(0));
  endtask

  initial begin
    rst_n                  = 1'b0;
    bus.load_req_in        = 1'b0;
    bus.mem_load_addr_in   = '0;
    bus.mem_m_load_size_in = '0;
    bus.mem_n_load_size_in = '0;
    bus.mem_col_major_in   = 1'b0;
    bus.mem_valid_in       = 1'b0;
    bus.mem_element_in     = '0;
    bus.reg_load_ready_in  = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_output("rst_req",       64'(bus.reg_load_req_out), 64'(0));
    check_output("rst_ack",       64'(bus.mem_load_ack_out), 64'(0));
    check_output("rst_err",       64'(bus.mem_load_error_out), 64'(0));
    check_output("rst_done",      64'(bus.load_done_out), 64'(0));
    check_output("rst_mem_ready", 64'(bus.mem_ready_out), 64'(0));
    check_output("rst_addr",      64'(bus.reg_load_addr_out), 64'(0));
    check_output("rst_m",         64'(bus.reg_m_load_size_out), 64'(0));
    check_output("rst_n_size",    64'(bus.reg_n_load_size_out), 64'(0));
    check_output("rst_elem",      64'(bus.reg_load_element_out), 64'(0));
    check_output("rst_mask",      64'(bus.reg_lane_valid_out), 64'(0));
    check_output("rst_i",         64'(bus.reg_i_load_loc_out), 64'(0));
    check_output("rst_j",         64'(bus.reg_j_load_loc_out), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    apply_stimulus(3, 3, 3, 1'b0, 1'b1);
    stream_load(3, 3, 1'b0, 1'b0, 1'b0);

    apply_stimulus(1, 0, 2, 1'b0, 1'b0);
    apply_stimulus(1, M + 1, 2, 1'b0, 1'b0);
    apply_stimulus(2, 2, 0, 1'b0, 1'b0);
    apply_stimulus(2, 2, N + 1, 1'b0, 1'b0);

    apply_stimulus(2, 1, 1, 1'b0, 1'b1);
    stream_load(1, 1, 1'b0, 1'b0, 1'b0);

    apply_stimulus(4, 2, 3, 1'b1, 1'b1);
    stream_load(2, 3, 1'b1, 1'b0, 1'b0);

    apply_stimulus(5, 4, 4, 1'b0, 1'b1);
    stream_load(4, 4, 1'b0, 1'b0, 1'b1);

    // Abort a 3x3 load while its second beat is on the output.
    apply_stimulus(6, 3, 3, 1'b0, 1'b1);
    @(negedge clk);
    bus.reg_load_ready_in = 1'b1;
    bus.mem_valid_in      = 1'b1;
    bus.mem_element_in    = {$urandom, $urandom};
    repeat (3) @(negedge clk);
    #1;
    check_output("mid_req_before_reset", 64'(bus.reg_load_req_out), 64'(1));
    rst_n = 1'b0;
    #1;
    check_output("abort_req",       64'(bus.reg_load_req_out), 64'(0));
    check_output("abort_mem_ready", 64'(bus.mem_ready_out), 64'(0));
    check_output("abort_addr",      64'(bus.reg_load_addr_out), 64'(0));
    check_output("abort_m",         64'(bus.reg_m_load_size_out), 64'(0));
    check_output("abort_elem",      64'(bus.reg_load_element_out), 64'(0));
    check_output("abort_done",      64'(bus.load_done_out), 64'(0));
    @(negedge clk);
    bus.mem_valid_in = 1'b0;
    rst_n            = 1'b1;
    last_addr        = 0;
    last_m           = 0;
    last_n           = 0;
    apply_stimulus(7, 2, 2, 1'b0, 1'b1);
    stream_load(2, 2, 1'b0, 1'b1, 1'b0);

    for (int t = 0; t < 10; t++) begin
      int rm, rn, ra;
      bit rc;
      rm = $urandom_range(1, M);
      rn = $urandom_range(1, N);
      ra = $urandom_range(0, (1 << AW) - 1);
      rc = 1'($urandom_range(0, 1));
      apply_stimulus(ra, rm, rn, rc, 1'b1);
      stream_load(rm, rn, rc, 1'b1, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
